// File: rtl/entry_gate_ctrl.sv
// entry_gate_ctrl: debounced entry/exit sensing and sequencing FSM for the speed-checked barrier.
// Times a vehicle between two beams, judges the divider result and drives the datapath strobes.
module entry_gate_ctrl #(
    parameter int WIDTH_SPEED = 14,
    parameter int SYS_FREQ    = 50000000,
    parameter int DEB_MS      = 5,
    parameter int MAX_VEH     = 3,
    parameter int SPEED_LIMIT = 20,
    parameter int TIMEOUT_MS  = 2000,
    parameter int BARRIER_MS  = 3000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   s1_in,
    input  logic                   s2_in,
    input  logic                   exit1_in,
    input  logic                   exit2_in,
    input  logic                   manual_open,
    input  logic                   manual_close,
    input  logic [1:0]             num_veh,
    input  logic [WIDTH_SPEED-1:0] speed,
    input  logic                   done,
    output logic                   init,
    output logic                   count,
    output logic                   cal,
    output logic                   up,
    output logic                   down,
    output logic                   down2,
    output logic                   en,
    output logic                   dis,
    output logic                   busy,
    output logic                   overspeed,
    output logic                   full_rej
);
    localparam int TICK_N = SYS_FREQ / 1000;
    localparam int CW     = TICK_N > 1 ? $clog2(TICK_N) : 1;
    localparam int DW     = DEB_MS > 1 ? $clog2(DEB_MS) : 1;
    localparam int TMAX   = TIMEOUT_MS > BARRIER_MS ? TIMEOUT_MS : BARRIER_MS;
    localparam int TW     = $clog2(TMAX + 1);
    localparam logic [CW-1:0]          TICK_END = CW'(TICK_N - 1);
    localparam logic [DW-1:0]          DEB_END  = DW'(DEB_MS - 1);
    localparam logic [TW-1:0]          T_OUT    = TW'(TIMEOUT_MS);
    localparam logic [TW-1:0]          T_BAR    = TW'(BARRIER_MS);
    localparam logic [2:0]             VEH_MAX  = 3'(MAX_VEH);
    localparam logic [WIDTH_SPEED-1:0] LIM      = WIDTH_SPEED'(SPEED_LIMIT);

    typedef enum logic [2:0] {IDLE, ARM, TIMING, ABORT, CALC, WAITDIV, DECIDE, HOLD} state_t;
    state_t state, nxt;

    logic [CW-1:0]          tcnt;
    logic [TW-1:0]          tmr;
    logic [5:0]             sy1, sy2;
    logic [3:0]             deb, deb_q, rise;
    logic [1:0]             man_q, mrise;
    logic [WIDTH_SPEED-1:0] spd_r;
    logic                   tick, done_r, pend1, pend2, close_pend, close_req, room, hold_end, reject;

    assign tick = tcnt == TICK_END;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) tcnt <= '0;
        else tcnt <= tick ? '0 : tcnt + 1'b1;

    // bits 3:0 are debounced sensors, bits 5:4 the manual requests (sync + edge only)
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sy1   <= '0;
            sy2   <= '0;
            deb_q <= '0;
            man_q <= '0;
        end else begin
            sy1   <= {manual_close, manual_open, exit2_in, exit1_in, s2_in, s1_in};
            sy2   <= sy1;
            deb_q <= deb;
            man_q <= sy2[5:4];
        end

    genvar i;
    for (i = 0; i < 4; i = i + 1) begin : g_deb
        logic [DW-1:0] dcnt;
        logic          lvl;
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                dcnt <= '0;
                lvl  <= 1'b0;
            end else if (sy2[i] == lvl) dcnt <= '0;
            else if (tick) begin
                dcnt <= dcnt == DEB_END ? '0 : dcnt + 1'b1;
                lvl  <= dcnt == DEB_END ? sy2[i] : lvl;
            end
        assign deb[i] = lvl;
    end

    assign rise  = deb & ~deb_q;
    assign mrise = sy2[5:4] & ~man_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state      <= IDLE;
            tmr        <= '0;
            done_r     <= 1'b0;
            spd_r      <= '0;
            overspeed  <= 1'b0;
            pend1      <= 1'b0;
            pend2      <= 1'b0;
            close_pend <= 1'b0;
        end else begin
            state      <= nxt;
            tmr        <= nxt != state ? '0 : tmr + TW'(tick);
            done_r     <= state == WAITDIV && done;
            spd_r      <= state == WAITDIV && done ? speed : spd_r;
            overspeed  <= state == ARM ? 1'b0 : overspeed | reject;
            pend1      <= (pend1 & ~down) | rise[2];
            pend2      <= (pend2 & ~down2) | rise[3];
            close_pend <= close_req & (en | up);
        end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = rise[0] && room ? ARM : IDLE;
            ARM:     nxt = TIMING;
            TIMING:  nxt = rise[1] ? (tmr == '0 ? IDLE : CALC) : (tmr == T_OUT ? ABORT : TIMING);
            ABORT:   nxt = IDLE;
            CALC:    nxt = WAITDIV;
            WAITDIV: nxt = done_r ? DECIDE : WAITDIV;
            DECIDE:  nxt = spd_r > LIM ? IDLE : HOLD;
            HOLD:    nxt = hold_end ? IDLE : HOLD;
            default: nxt = IDLE;
        endcase
    end

    assign room      = {1'b0, num_veh} < VEH_MAX;
    assign hold_end  = state == HOLD && tmr == T_BAR;
    assign reject    = (state == TIMING && rise[1] && tmr == '0) || (state == DECIDE && spd_r > LIM);
    assign init      = state == ARM || state == ABORT;
    assign count     = state == TIMING;
    assign cal       = state == CALC;
    assign up        = state == DECIDE && spd_r <= LIM;
    // up wins the decrement slot; exit pulses wait in pend1/pend2
    assign down      = pend1 & ~up;
    assign down2     = pend2 & ~pend1 & ~up;
    assign en        = mrise[0];
    assign close_req = mrise[1] | close_pend;
    assign dis       = (close_req & ~en & ~up) | hold_end;
    assign busy      = state != IDLE;
    assign full_rej  = state == IDLE && rise[0] && !room;
endmodule

// File: tb/tb_entry_gate_ctrl.sv
// tb_entry_gate_ctrl: directed and randomized checks of entry_gate_ctrl against a ms-tick timing model
// and a behavioural datapath (vehicle count, divider handshake).
module tb_entry_gate_ctrl;
    localparam int SYS_FREQ    = 10000;
    localparam int DEB_MS      = 2;
    localparam int BARRIER_MS  = 5;
    localparam int TIMEOUT_MS  = 50;
    localparam int SPEED_LIMIT = 20;
    localparam int TK          = SYS_FREQ / 1000;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        s1_in = 1'b0, s2_in = 1'b0, exit1_in = 1'b0, exit2_in = 1'b0;
    logic        manual_open = 1'b0, manual_close = 1'b0, done = 1'b0;
    logic [13:0] speed = '0;
    logic [1:0]  num_veh, nv = 2'd0;
    logic        force_full = 1'b0;
    logic        init, count, cal, up, down, down2, en, dis, busy, overspeed, full_rej;
    logic [7:0]  ev;
    int          checks = 0, errors = 0, cyc = 0;
    int          n_ev[8] = '{default: 0};
    int          t_ev[8] = '{default: 0};
    int          r, e, g, n0, n1;

    entry_gate_ctrl #(
        .WIDTH_SPEED(14), .SYS_FREQ(SYS_FREQ), .DEB_MS(DEB_MS), .MAX_VEH(3),
        .SPEED_LIMIT(SPEED_LIMIT), .TIMEOUT_MS(TIMEOUT_MS), .BARRIER_MS(BARRIER_MS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .s1_in(s1_in), .s2_in(s2_in), .exit1_in(exit1_in),
        .exit2_in(exit2_in), .manual_open(manual_open), .manual_close(manual_close),
        .num_veh(num_veh), .speed(speed), .done(done), .init(init), .count(count), .cal(cal),
        .up(up), .down(down), .down2(down2), .en(en), .dis(dis), .busy(busy),
        .overspeed(overspeed), .full_rej(full_rej)
    );

    always #5 clk = ~clk;

    always_comb num_veh = force_full ? 2'd3 : nv;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;

    // event recorder: pulse counts, cycle stamps, datapath vehicle count
    always @(negedge clk)
        if (reset_n) begin
            ev = {full_rej, en, down2, down, dis, up, cal, init};
            for (int k = 0; k < 8; k++)
                if (ev[k]) begin
                    n_ev[k]++;
                    t_ev[k] = cyc;
                end
            if (up | down | down2) begin
                checks++;
                assert (int'(up) + int'(down) + int'(down2) == 1) else begin
                    errors++;
                    $error("FAIL exclusive up=%0b down=%0b down2=%0b expected exactly one", up, down, down2);
                end
            end
            if (up && nv != 2'd3) nv = nv + 2'd1;
            else if ((down || down2) && nv != 2'd0) nv = nv - 2'd1;
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_ev(input string tag, input int k, input int base, input int lim);
        for (int i = 0; i < lim && n_ev[k] == base; i++) step();
        chk({tag, "_seen"}, 32'(n_ev[k] != base), 1);
    endtask

    // edge at which a ms count started at edge s reaches ms ticks (ticks land on multiples of TK)
    function automatic int after_ms(input int s, input int ms);
        return (s / TK + 1) * TK + TK * (ms - 1);
    endfunction

    // edge at which a raw level driven at cycle r is accepted by the 2-FF sync + debouncer
    function automatic int acc(input int r);
        return after_ms(r + 2, DEB_MS);
    endfunction

    task automatic vehicle(input int gap, input int spd, input int lat);
        int rv, ei, dc, nu;
        nu = n_ev[2];
        rv = cyc;
        s1_in = 1'b1;
        wait_ev("arm", 0, n_ev[0], 100);
        chk("arm_lat", t_ev[0], acc(rv) + 1);
        ei = t_ev[0];
        step();
        chk("ov_clear", overspeed, 0);
        step(gap * TK - (cyc - rv));
        chk("timing_count", count, 1);
        rv = cyc;
        s2_in = 1'b1;
        wait_ev("cal", 1, n_ev[1], 100);
        chk("cal_lat", t_ev[1], acc(rv) + 1);
        step(lat);
        dc = cyc;
        done = 1'b1;
        speed = 14'(spd);
        step();
        done = 1'b0;
        if (spd > SPEED_LIMIT) begin
            step(4);
            chk("ov_set", overspeed, 1);
            chk("ov_no_up", n_ev[2], nu);
            chk("ov_idle", busy, 0);
        end else begin
            wait_ev("up", 2, nu, 20);
            chk("up_lat", t_ev[2], dc + 2);
            wait_ev("hold_dis", 3, n_ev[3], 100);
            chk("hold_dis_lat", t_ev[3], after_ms(t_ev[2] + 1, BARRIER_MS));
            step();
            chk("hold_idle", busy, 0);
        end
        s1_in = 1'b0;
        s2_in = 1'b0;
        step(40);
        if (ei < 0) chk("arm_order", ei, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        chk("rst_outs", {init, count, cal, up, down, down2, en, dis, busy, overspeed, full_rej}, 0);
        reset_n = 1'b1;
        step(2);
        chk("idle_busy", busy, 0);
        chk("idle_outs", {init, count, cal, up, down, down2, en, dis, overspeed, full_rej}, 0);

        // manual open, simultaneous open+close (close deferred), close alone
        n0 = n_ev[6];
        r = cyc;
        manual_open = 1'b1;
        wait_ev("en", 6, n0, 10);
        chk("en_lat", t_ev[6], r + 2);
        step(5);
        chk("en_once", n_ev[6], n0 + 1);
        manual_open = 1'b0;
        step(5);
        r = cyc;
        manual_open = 1'b1;
        manual_close = 1'b1;
        wait_ev("dis_defer", 3, n_ev[3], 10);
        chk("dis_defer_lat", t_ev[3], r + 3);
        chk("en_both_lat", t_ev[6], r + 2);
        manual_open = 1'b0;
        manual_close = 1'b0;
        step(5);
        r = cyc;
        manual_close = 1'b1;
        wait_ev("dis_man", 3, n_ev[3], 10);
        chk("dis_man_lat", t_ev[3], r + 2);
        manual_close = 1'b0;
        step(5);

        // 1 ms glitch on beam 1 must not arm
        n0 = n_ev[0];
        s1_in = 1'b1;
        step(TK);
        s1_in = 1'b0;
        step(60);
        chk("glitch_noinit", n_ev[0], n0);

        vehicle(12, 14400 / 12, 3);
        vehicle(12, 15, 2);
        g = $urandom_range(5, 40);
        vehicle(g, ($urandom_range(0, 1) != 0) ? 14400 / g : int'($urandom_range(0, 40)), $urandom_range(1, 4));

        // beam 2 never arrives: abort after the timeout
        n1 = n_ev[1];
        r = cyc;
        s1_in = 1'b1;
        wait_ev("to_arm", 0, n_ev[0], 100);
        chk("to_arm_lat", t_ev[0], acc(r) + 1);
        e = t_ev[0];
        step();
        wait_ev("to_abort", 0, n_ev[0], 700);
        chk("to_abort_lat", t_ev[0], after_ms(e + 1, TIMEOUT_MS) + 1);
        step();
        chk("to_idle", busy, 0);
        chk("to_nocal", n_ev[1], n1);
        s1_in = 1'b0;
        step(40);

        // both exits accepted in the same cycle as up
        s1_in = 1'b1;
        wait_ev("col_arm", 0, n_ev[0], 100);
        step(100);
        s2_in = 1'b1;
        wait_ev("col_cal", 1, n_ev[1], 100);
        step(2);
        r = cyc;
        exit1_in = 1'b1;
        exit2_in = 1'b1;
        e = acc(r);
        step(e - 2 - cyc);
        done = 1'b1;
        speed = 14'd10;
        step();
        done = 1'b0;
        wait_ev("col_up", 2, n_ev[2], 20);
        chk("col_up_lat", t_ev[2], e);
        wait_ev("col_down", 4, n_ev[4], 5);
        chk("col_down_lat", t_ev[4], e + 1);
        wait_ev("col_down2", 5, n_ev[5], 5);
        chk("col_down2_lat", t_ev[5], e + 2);
        wait_ev("col_dis", 3, n_ev[3], 100);
        exit1_in = 1'b0;
        exit2_in = 1'b0;
        s1_in = 1'b0;
        s2_in = 1'b0;
        step(40);

        // full: refuse with a single pulse and stay idle
        force_full = 1'b1;
        n0 = n_ev[0];
        n1 = n_ev[7];
        r = cyc;
        s1_in = 1'b1;
        wait_ev("full", 7, n1, 100);
        chk("full_lat", t_ev[7], acc(r));
        step(5);
        chk("full_noinit", n_ev[0], n0);
        chk("full_busy", busy, 0);
        chk("full_once", n_ev[7], n1 + 1);
        s1_in = 1'b0;
        force_full = 1'b0;
        step(40);

        // reset while waiting for the divider
        s1_in = 1'b1;
        wait_ev("wd_arm", 0, n_ev[0], 100);
        step(80);
        s2_in = 1'b1;
        wait_ev("wd_cal", 1, n_ev[1], 100);
        step(3);
        chk("wd_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async", {init, count, cal, up, down, down2, en, dis, busy, overspeed, full_rej}, 0);
        s1_in = 1'b0;
        s2_in = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(30);
        chk("rst_idle", busy, 0);
        n0 = n_ev[2];
        done = 1'b1;
        speed = 14'd5;
        step();
        done = 1'b0;
        step(5);
        chk("rst_no_up", n_ev[2], n0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
